// File: rtl/dll_replay_ctrl.sv
// Transmit-side data link retry controller: tracks NEXT_TRANSMIT_SEQ/ACKD_SEQ, runs the replay
// timer and REPLAY_NUM, and drives purge/replay/stall. Define DLL_REPLAY_RETRAIN_EN for retrain.
module dll_replay_ctrl #(
  parameter int unsigned REPLAY_TIMEOUT = 711,
  parameter int unsigned TIMER_WIDTH    = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        phy_link_up_i,
  input  logic [11:0] seq_num_i,
  input  logic        seq_num_vld_i,
  input  logic        seq_num_acknack_i,
  input  logic        tlp_sent_i,
  input  logic        replay_done_i,
  output logic [11:0] tx_seq_num_o,
  output logic [11:0] ackd_seq_o,
  output logic        purge_vld_o,
  output logic [11:0] purge_seq_o,
  output logic        replay_req_o,
  output logic        retrain_req_o,
  output logic        tx_stall_o,
  output logic        dl_error_o
);

  typedef enum logic [1:0] {StLinkDown, StActive, StReplay} state_e;

  localparam logic [TIMER_WIDTH-1:0] TimerLast = TIMER_WIDTH'(REPLAY_TIMEOUT - 1);

  state_e                 state_q, state_d;
  logic [11:0]            tx_seq_q, tx_seq_d;
  logic [11:0]            ackd_q, ackd_d;
  logic [11:0]            purge_seq_q, purge_seq_d;
  logic [1:0]             replay_num_q, replay_num_d;
  logic [TIMER_WIDTH-1:0] timer_q, timer_d;
  logic                   purge_vld_q, purge_vld_d;
  logic                   dl_error_q, dl_error_d;
`ifdef DLL_REPLAY_RETRAIN_EN
  logic                   retrain_q, retrain_d;
`endif

  logic [11:0] outstanding, back_dist, fwd_dist;
  logic        seq_ok, progress, nak_trig, expire, trigger, stall;
  logic [1:0]  rnum_base;

  assign outstanding = tx_seq_q - ackd_q - 12'd1;
  assign stall       = (outstanding >= 12'd2047) || (state_q == StReplay);
  // Both distances must fall in the lower half of the 12-bit sequence space.
  assign back_dist   = tx_seq_q - 12'd1 - seq_num_i;
  assign fwd_dist    = seq_num_i - ackd_q;
  assign seq_ok      = !back_dist[11] && !fwd_dist[11];

  always_comb begin
    state_d      = state_q;
    tx_seq_d     = tx_seq_q;
    ackd_d       = ackd_q;
    purge_seq_d  = purge_seq_q;
    replay_num_d = replay_num_q;
    timer_d      = timer_q;
    purge_vld_d  = 1'b0;
    dl_error_d   = 1'b0;
`ifdef DLL_REPLAY_RETRAIN_EN
    retrain_d    = 1'b0;
`endif
    progress     = 1'b0;
    nak_trig     = 1'b0;
    expire       = 1'b0;
    trigger      = 1'b0;
    rnum_base    = replay_num_q;

    if (!phy_link_up_i) begin
      state_d      = StLinkDown;
      tx_seq_d     = 12'd0;
      ackd_d       = 12'hFFF;
      purge_seq_d  = 12'd0;
      replay_num_d = 2'd0;
      timer_d      = '0;
    end else begin
      unique case (state_q)
        StLinkDown: state_d = StActive;
        StActive, StReplay: begin
          if (seq_num_vld_i) begin
            if (seq_ok) begin
              if (seq_num_i != ackd_q) begin
                progress    = 1'b1;
                ackd_d      = seq_num_i;
                purge_vld_d = 1'b1;
                purge_seq_d = seq_num_i;
              end
              nak_trig = !seq_num_acknack_i && (state_q == StActive);
            end else begin
              dl_error_d = 1'b1;
            end
          end

          expire  = (state_q == StActive) && !progress && (outstanding != 12'd0) &&
                    (timer_q == TimerLast);
          trigger = nak_trig || expire;

          // Forward progress in the same event clears REPLAY_NUM before any replay counts.
          rnum_base    = progress ? 2'd0 : replay_num_q;
          replay_num_d = rnum_base;
          if (trigger) begin
            state_d = StReplay;
            if (rnum_base == 2'd3) begin
`ifdef DLL_REPLAY_RETRAIN_EN
              replay_num_d = 2'd0;
              retrain_d    = 1'b1;
`else
              replay_num_d = 2'd3;
`endif
            end else begin
              replay_num_d = rnum_base + 2'd1;
            end
          end else if ((state_q == StReplay) && replay_done_i) begin
            state_d = StActive;
          end

          if (trigger || progress || ((state_q == StActive) && (outstanding == 12'd0))) begin
            timer_d = '0;
          end else if (state_q == StActive) begin
            timer_d = timer_q + 1'b1;
          end

          if ((state_q == StActive) && !stall && tlp_sent_i) begin
            tx_seq_d = tx_seq_q + 12'd1;
          end
        end
        default: state_d = StLinkDown;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StLinkDown;
      tx_seq_q     <= 12'd0;
      ackd_q       <= 12'hFFF;
      purge_seq_q  <= 12'd0;
      replay_num_q <= 2'd0;
      timer_q      <= '0;
      purge_vld_q  <= 1'b0;
      dl_error_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_seq_q     <= tx_seq_d;
      ackd_q       <= ackd_d;
      purge_seq_q  <= purge_seq_d;
      replay_num_q <= replay_num_d;
      timer_q      <= timer_d;
      purge_vld_q  <= purge_vld_d;
      dl_error_q   <= dl_error_d;
    end
  end

`ifdef DLL_REPLAY_RETRAIN_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      retrain_q <= 1'b0;
    end else begin
      retrain_q <= retrain_d;
    end
  end
  assign retrain_req_o = retrain_q;
`else
  assign retrain_req_o = 1'b0;
`endif

  assign tx_seq_num_o = tx_seq_q;
  assign ackd_seq_o   = ackd_q;
  assign purge_vld_o  = purge_vld_q;
  assign purge_seq_o  = purge_seq_q;
  assign replay_req_o = (state_q == StReplay);
  assign tx_stall_o   = stall;
  assign dl_error_o   = dl_error_q;

endmodule

// File: tb/tb_dll_replay_ctrl.sv
// Scoreboard bench for dll_replay_ctrl: a sequence-space reference model predicts pulse events
// and register levels; a negedge monitor compares. Honours DLL_REPLAY_RETRAIN_EN.
module tb_dll_replay_ctrl;

  localparam int TO = 2100;

  logic        clk, rst, phy_up, seq_vld, acknak, tlp_sent, replay_done;
  logic [11:0] seq_num;
  logic [11:0] tx_seq_num_o, ackd_seq_o, purge_seq_o;
  logic        purge_vld_o, replay_req_o, retrain_req_o, tx_stall_o, dl_error_o;

  dll_replay_ctrl #(.REPLAY_TIMEOUT(TO), .TIMER_WIDTH(16)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .phy_link_up_i    (phy_up),
    .seq_num_i        (seq_num),
    .seq_num_vld_i    (seq_vld),
    .seq_num_acknack_i(acknak),
    .tlp_sent_i       (tlp_sent),
    .replay_done_i    (replay_done),
    .tx_seq_num_o     (tx_seq_num_o),
    .ackd_seq_o       (ackd_seq_o),
    .purge_vld_o      (purge_vld_o),
    .purge_seq_o      (purge_seq_o),
    .replay_req_o     (replay_req_o),
    .retrain_req_o    (retrain_req_o),
    .tx_stall_o       (tx_stall_o),
    .dl_error_o       (dl_error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int retrain_seen = 0;

  // kind: 0 purge, 1 dl_error, 2 retrain, 3 replay start
  typedef struct {int kind; int cyc; int val;} ev_t;
  ev_t exp_q[$];
  string ev_name[4] = '{"purge", "dl_error", "retrain", "replay_start"};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: plain modulo-4096 sequence arithmetic, updated once per clock.
  int m_tx, m_ackd, m_rnum, m_wait;
  bit m_up, m_replay;

  function automatic bit m_stall();
    return m_replay || (((m_tx - m_ackd - 1) & 4095) >= 2047);
  endfunction

  always @(posedge clk) begin : model
    int out, seq, base;
    bit prog, trig, stalled;
    cyc++;
    if (rst || !phy_up) begin
      m_up = 0; m_replay = 0; m_tx = 0; m_ackd = 4095; m_rnum = 0; m_wait = 0;
    end else if (!m_up) begin
      m_up = 1;
    end else begin
      out     = (m_tx - m_ackd - 1) & 4095;
      stalled = m_stall();
      prog    = 0;
      trig    = 0;
      seq     = int'(seq_num);
      if (seq_vld) begin
        if ((((m_tx - 1 - seq) & 4095) < 2048) && (((seq - m_ackd) & 4095) < 2048)) begin
          if (seq != m_ackd) begin
            prog = 1;
            exp_q.push_back(ev_t'{0, cyc, seq});
          end
          if (!acknak && !m_replay) trig = 1;
        end else begin
          exp_q.push_back(ev_t'{1, cyc, 0});
        end
      end
      // Waiting cycles without progress while something is outstanding.
      if (!m_replay && !prog && out != 0 && m_wait + 1 >= TO) trig = 1;
      base = prog ? 0 : m_rnum;
      if (trig) begin
        if (base == 3) begin
`ifdef DLL_REPLAY_RETRAIN_EN
          m_rnum = 0;
          exp_q.push_back(ev_t'{2, cyc, 0});
`else
          m_rnum = 3;
`endif
        end else begin
          m_rnum = base + 1;
        end
        exp_q.push_back(ev_t'{3, cyc, 0});
      end else begin
        m_rnum = base;
      end
      if (trig || prog || (!m_replay && out == 0)) m_wait = 0;
      else if (!m_replay) m_wait++;
      if (!stalled && tlp_sent) m_tx = (m_tx + 1) & 4095;
      if (prog) m_ackd = seq;
      if (trig) m_replay = 1;
      else if (m_replay && replay_done) m_replay = 0;
    end
  end

  bit prev_replay = 0;

  task automatic observe(input int k, input int val);
    ev_t e;
    if (exp_q.size() != 0 && exp_q[0].cyc == cyc && exp_q[0].kind == k) begin
      e = exp_q.pop_front();
      if (k == 0) check("purge_seq", val, e.val);
      else checks++;
    end else begin
      checks++;
      errors++;
      $display("FAIL %s_event actual present required absent (cycle %0d)", ev_name[k], cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    ev_t e;
    if (cyc > 0) begin
      check("tx_seq", tx_seq_num_o, m_tx);
      check("ackd_seq", ackd_seq_o, m_ackd);
      check("tx_stall", tx_stall_o, m_stall());
      check("replay_req", replay_req_o, m_replay);
      if (purge_vld_o === 1'b1) observe(0, int'(purge_seq_o));
      if (dl_error_o === 1'b1) observe(1, 0);
      if (retrain_req_o === 1'b1) begin
        retrain_seen++;
        observe(2, 0);
      end
      if (replay_req_o === 1'b1 && !prev_replay) observe(3, 0);
      prev_replay = (replay_req_o === 1'b1);
      while (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL %s_event actual absent required present (cycle %0d)", ev_name[e.kind],
                 e.cyc);
      end
    end
  end

  task automatic drive(input bit tlp, input bit vld, input int seq, input bit ack, input bit done);
    @(negedge clk);
    tlp_sent    = tlp;
    seq_vld     = vld;
    seq_num     = seq[11:0];
    acknak      = ack;
    replay_done = done;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0);
  endtask

  task automatic link_bounce();
    drive(0, 0, 0, 0, 0);
    phy_up = 0;
    drive(0, 0, 0, 0, 0);
    phy_up = 1;
  endtask

  task automatic wait_replay(input string name, input int budget);
    int n = 0;
    while (replay_req_o !== 1'b1 && n < budget) begin
      idle(1);
      n++;
    end
    check({name, "_reached"}, replay_req_o, 1);
  endtask

  initial begin
    int r, seq, out;
    rst = 1; phy_up = 0; seq_vld = 0; acknak = 0; tlp_sent = 0; replay_done = 0; seq_num = 0;
    idle(3);
    check("rst_tx_seq", tx_seq_num_o, 0);
    check("rst_ackd", ackd_seq_o, 12'hFFF);
    check("rst_purge_vld", purge_vld_o, 0);
    check("rst_replay_req", replay_req_o, 0);
    check("rst_stall", tx_stall_o, 0);
    check("rst_dl_error", dl_error_o, 0);
    check("rst_retrain", retrain_req_o, 0);
    rst = 0;
    phy_up = 1;
    idle(2);

    // Five sends, Ack 2.
    repeat (5) drive(1, 0, 0, 0, 0);
    drive(0, 1, 2, 1, 0);
    idle(1);
    check("t1_tx_seq", tx_seq_num_o, 5);
    check("t1_ackd", ackd_seq_o, 2);
    check("t1_no_replay", replay_req_o, 0);

    // Nak 0 after three sends starts a replay.
    link_bounce();
    repeat (3) drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    idle(1);
    check("t2_replay_req", replay_req_o, 1);
    check("t2_stall", tx_stall_o, 1);
    repeat (2) drive(1, 0, 0, 0, 0);
    idle(3);
    check("t2_tx_held", tx_seq_num_o, 3);
    drive(0, 0, 0, 0, 1);
    idle(1);
    check("t2_replay_end", replay_req_o, 0);

    // Four timer expiries with one TLP outstanding.
    link_bounce();
    drive(1, 0, 0, 0, 0);
    retrain_seen = 0;
    for (int i = 0; i < 4; i++) begin
      wait_replay("t3_expiry", TO + 20);
      drive(0, 0, 0, 0, 1);
    end
    idle(2);
`ifdef DLL_REPLAY_RETRAIN_EN
    check("t3_retrain_pulses", retrain_seen, 1);
`else
    check("t3_retrain_pulses", retrain_seen, 0);
`endif

    // 4100 sends acked through the wrap, then Ack 4095 followed by Ack 3.
    link_bounce();
    for (int i = 0; i < 4100; i++) begin
      if (i >= 1 && !(i - 1 >= 4096 && i - 1 <= 4098)) drive(1, 1, (i - 1) & 4095, 1, 0);
      else drive(1, 0, 0, 0, 0);
    end
    drive(0, 1, 3, 1, 0);
    idle(1);
    check("t4_tx_wrap", tx_seq_num_o, 4);
    check("t4_ackd", ackd_seq_o, 3);

    // Ack beyond next-1 is a DL error.
    link_bounce();
    repeat (4) drive(1, 0, 0, 0, 0);
    drive(0, 1, 100, 1, 0);
    idle(1);
    check("t5_dl_error", dl_error_o, 1);
    check("t5_ackd_held", ackd_seq_o, 12'hFFF);

    // Fill the window, then lose the link mid-replay.
    link_bounce();
    repeat (2047) drive(1, 0, 0, 0, 0);
    repeat (10) drive(1, 0, 0, 0, 0);
    idle(1);
    check("t6_stall", tx_stall_o, 1);
    check("t6_tx_held", tx_seq_num_o, 2047);
    wait_replay("t6_expiry", 200);
    idle(3);
    drive(0, 0, 0, 0, 0);
    phy_up = 0;
    idle(1);
    check("t6_down_tx", tx_seq_num_o, 0);
    check("t6_down_ackd", ackd_seq_o, 12'hFFF);
    check("t6_down_replay", replay_req_o, 0);
    phy_up = 1;
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      r   = $urandom_range(0, 9);
      out = (m_tx - m_ackd - 1) & 4095;
      if (r < 8) seq = (m_ackd + $urandom_range(0, out + 1)) & 4095;
      else seq = $urandom_range(0, 4095);
      drive($urandom_range(0, 1), $urandom_range(0, 4) == 0, seq, $urandom_range(0, 2) != 0,
            $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 499) == 0) begin
        phy_up = 0;
        drive(0, 0, 0, 0, 0);
        phy_up = 1;
      end
    end
    idle(3);
    check("end_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
